prirv32_mem_arbiter: RTL and testbench
======================================

Name: prirv32_mem_arbiter

Overview:
- Shares one single-port synchronous SRAM between the priRV32 instruction-fetch (IF) port and the load/store data (D) port.
- Issues at most one memory access per cycle and routes the 1-cycle-latency read data back to the owning requester.
- Default policy is fixed priority to D, with a starvation guard for IF.
- Sits between the core pipeline and the on-chip memory that the top-level priRV32 instance drives.

Parameters:
- MEM_AW, 12, word-address width of the SRAM (depth 2^MEM_AW x 32 bit).
- STARVE_MAX, 4, maximum number of consecutive cycles IF may be denied while valid before it is forced a grant. Range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request pending.
- if_req_ready  out  1  fetch request granted this cycle.
- if_addr  in  32  fetch byte address.
- if_rsp_valid  out  1  fetch read data valid.
- if_rdata  out  32  fetch read data.
- d_req_valid  in  1  data request pending.
- d_req_ready  out  1  data request granted this cycle.
- d_addr  in  32  data byte address.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  4  store byte enables.
- d_wdata  in  32  store data.
- d_rsp_valid  out  1  load data, or store acknowledge.
- d_rdata  out  32  load data; 0 for a store acknowledge.
- mem_en  out  1  SRAM access enable.
- mem_we  out  4  SRAM per-byte write enables.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  32  SRAM write data.
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en.

Behaviour:
- Reset: the clock is clk; the reset is synchronous and active-high.
  - While reset = 1, all of the following are 0: if_req_ready, d_req_ready, mem_en, mem_we.
  - Registered outputs reset to 0 on the edge: if_rsp_valid, d_rsp_valid, if_rdata, d_rdata.
  - Internal state reset: starve counter = 0; response pipeline register empty.
- Grant logic (combinational from the valids and registered state):
  - A transfer occurs when valid && ready.
  - ready may depend on valid. Requesters must hold address and data stable while valid && !ready.
- Fixed-priority arbitration:
  - Only one valid: that requester is granted.
  - Both valid: D is granted, unless starve_cnt == STARVE_MAX, in which case IF is granted.
- Starve counter (4 bit):
  - Increments when if_req_valid && !if_req_ready.
  - Clears on an IF grant, or when if_req_valid = 0.
  - Saturates at STARVE_MAX.
- Memory drive (combinational from the granted request):
  - mem_en = 1.
  - mem_addr = addr[MEM_AW+1:2].
  - Address bits [1:0] and bits above MEM_AW+1 are ignored, so out-of-range addresses wrap.
  - mem_we = d_be when D is granted with d_we = 1; otherwise 0.
  - mem_wdata = d_wdata.
- Response pipeline (1 stage): the register captures {valid, owner, is_store} on every grant.
  - Next cycle, exactly one of if_rsp_valid / d_rsp_valid pulses for 1 cycle.
  - Read data is mem_rdata registered into the owner's rdata output. The rdata outputs hold their value otherwise.
  - Store acknowledge: d_rsp_valid = 1 and d_rdata = 0.
  - Latency is request grant to response = 1 cycle.
- Throughput: back-to-back grants every cycle; no bubbles.
- Responses have no backpressure; requesters must accept them.
- Reset mid-operation: an outstanding response is dropped and its rsp_valid stays 0. A write granted in the same cycle reset is asserted is not performed.
- Simultaneous events: a grant plus a response in the same cycle is normal pipelined operation.

Optional Feature:
- Macro: PRIRV32_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both are valid, the grant goes to the requester not granted most recently.
  - A last_owner register resets to IF, so D wins the first conflict.
  - The starve counter and STARVE_MAX are unused.
- Not defined: fixed priority with the starvation guard, as above.

Decomposition:
- Package prirv32_arb_pkg:
  - owner_e enum (OWN_IF, OWN_D).
  - rsp_slot_t struct {valid, owner_e owner, is_store}.
  - Constant STARVE_W = 4.
- Sub-module prirv32_arb_pick:
  - Pure grant decision.
  - Inputs: the two valids, starve_cnt / last_owner.
  - Outputs: the two grants.
  - Instanced once, so each policy can be unit-tested in isolation.

Test Plan:
- Reset then IF alone: if_addr = 0x0000_0010, SRAM word 4 = 0xDEAD_BEEF -> if_req_ready = 1, mem_addr = 4, next cycle if_rsp_valid = 1 and if_rdata = 0xDEAD_BEEF; d_rsp_valid = 0.
- Store then load: d_addr = 0x20, d_we = 1, d_be = 4'b0011, d_wdata = 0x1234_5678 over word 0xAABB_CCDD -> mem_we = 4'b0011, d_rsp_valid with d_rdata = 0. Subsequent load returns 0xAABB_5678.
- Both valid continuously, fixed priority, STARVE_MAX = 4 -> grant pattern D, D, D, D, IF repeating; IF response 1 cycle after each IF grant.
- Same stimulus with PRIRV32_ARB_RR_EN -> strict alternation D, IF, D, IF; every grant followed by exactly one response pulse.
- Wrap: d_addr = 0x0000_4008 with MEM_AW = 12 -> mem_addr = 2.
- Reset asserted the cycle after a load grant -> d_rsp_valid stays 0, all outputs 0 during reset, normal grant on the first cycle after reset deasserts.

Source files
------------

// File: rtl/prirv32_arb_pkg.sv
// ---------------------------------------------------------------------------
// prirv32_arb_pkg
//
// Shared types and constants for the priRV32 memory arbiter.
//   owner_e    : which requester owns an access (instruction fetch or data).
//   rsp_slot_t : contents of the one-deep response pipeline register.
//   STARVE_W   : width of the fetch starvation counter.
//
// Optional feature macro used by the files that import this package:
//   PRIRV32_ARB_RR_EN - round-robin arbitration instead of fixed priority.
// ---------------------------------------------------------------------------
package prirv32_arb_pkg;

   localparam int unsigned STARVE_W = 4;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_D  = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   is_store;
   } rsp_slot_t;

endpackage : prirv32_arb_pkg

// File: rtl/prirv32_arb_pick.sv
// ---------------------------------------------------------------------------
// prirv32_arb_pick
//
// Pure combinational grant decision between the fetch (IF) and data (D)
// requesters. Reset gating is done by the caller.
//
// Policy selected by macro PRIRV32_ARB_RR_EN:
//   undefined : D wins a conflict unless IF has been denied STARVE_MAX
//               consecutive cycles (starve_cnt_i == STARVE_MAX).
//   defined   : a conflict goes to the requester not granted most recently.
//
// Ports:
//   if_valid_i    in   IF request pending
//   d_valid_i     in   D request pending
//   starve_cnt_i  in   consecutive IF denials (fixed-priority build only)
//   last_owner_i  in   most recent grant owner (round-robin build only)
//   if_gnt_o      out  IF granted
//   d_gnt_o       out  D granted
// ---------------------------------------------------------------------------
module prirv32_arb_pick
   import prirv32_arb_pkg::*;
`ifndef PRIRV32_ARB_RR_EN
#(
   parameter int unsigned STARVE_MAX = 4
)
`endif
(
   input  logic                if_valid_i,
   input  logic                d_valid_i,
`ifdef PRIRV32_ARB_RR_EN
   input  owner_e              last_owner_i,
`else
   input  logic [STARVE_W-1:0] starve_cnt_i,
`endif
   output logic                if_gnt_o,
   output logic                d_gnt_o
);

   // IF wins when it is alone, or when the conflict tie-break favours it.
   // D simply takes whatever IF does not.
   always_comb begin
      if_gnt_o = 1'b0;
      d_gnt_o  = 1'b0;
`ifdef PRIRV32_ARB_RR_EN
      if_gnt_o = if_valid_i & (~d_valid_i | (last_owner_i == OWN_D));
`else
      if_gnt_o = if_valid_i &
                 (~d_valid_i | (starve_cnt_i == STARVE_W'(STARVE_MAX)));
`endif
      d_gnt_o  = d_valid_i & ~if_gnt_o;
   end

endmodule : prirv32_arb_pick

// File: rtl/prirv32_mem_arbiter.sv
// ---------------------------------------------------------------------------
// prirv32_mem_arbiter
//
// Shares one single-port synchronous SRAM (1-cycle read latency) between the
// priRV32 instruction-fetch port and the load/store data port. At most one
// access is issued per cycle; the read data is steered back to the owner of
// the access one cycle after the grant. Back-to-back grants every cycle.
//
// Handshake: a request transfers in the cycle where valid && ready. ready is
// combinational and may depend on valid; a requester holds address/data
// stable while valid && !ready. Responses carry no backpressure: exactly one
// rsp_valid pulses for one cycle after each grant (store ack has rdata = 0).
//
// Optional feature macro:
//   PRIRV32_ARB_RR_EN - round-robin conflict resolution; the starvation
//                       counter and STARVE_MAX are then unused.
//
// Parameters:
//   MEM_AW      word-address width of the SRAM (2^MEM_AW x 32 bit)
//   STARVE_MAX  max consecutive IF denials before IF is forced (1..15)
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   if_req_valid/if_req_ready    fetch request handshake, if_addr byte address
//   if_rsp_valid/if_rdata        fetch response
//   d_req_valid/d_req_ready      data request handshake
//   d_addr/d_we/d_be/d_wdata     data request payload
//   d_rsp_valid/d_rdata          load data or store acknowledge
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   SRAM interface
// ---------------------------------------------------------------------------
module prirv32_mem_arbiter
   import prirv32_arb_pkg::*;
#(
   parameter int unsigned MEM_AW     = 12,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   // instruction fetch port
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [31:0]       if_addr,
   output logic              if_rsp_valid,
   output logic [31:0]       if_rdata,
   // data port
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic [31:0]       d_addr,
   input  logic              d_we,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_wdata,
   output logic              d_rsp_valid,
   output logic [31:0]       d_rdata,
   // SRAM port
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   rsp_slot_t           slot_q, slot_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [31:0]         d_rdata_q, d_rdata_d;
`ifdef PRIRV32_ARB_RR_EN
   owner_e              last_owner_q, last_owner_d;
   logic [STARVE_W-1:0] unused_starve_cfg;
`else
   logic [STARVE_W-1:0] starve_q, starve_d;
`endif

   logic if_gnt_raw, d_gnt_raw;
   logic if_gnt, d_gnt;
   logic if_rsp_act, d_rsp_act;
   logic unused_addr_bits;

   // Byte-offset bits and bits above the SRAM range are dropped, so
   // out-of-range addresses alias onto the SRAM.
   assign unused_addr_bits = ^{if_addr[31:MEM_AW+2], if_addr[1:0],
                               d_addr[31:MEM_AW+2],  d_addr[1:0]};

   // ------------------------------------------------------------------
   // Grant decision
   // ------------------------------------------------------------------
`ifdef PRIRV32_ARB_RR_EN
   assign unused_starve_cfg = STARVE_W'(STARVE_MAX);

   prirv32_arb_pick u_pick (
      .if_valid_i   (if_req_valid),
      .d_valid_i    (d_req_valid),
      .last_owner_i (last_owner_q),
      .if_gnt_o     (if_gnt_raw),
      .d_gnt_o      (d_gnt_raw)
   );
`else
   prirv32_arb_pick #(
      .STARVE_MAX (STARVE_MAX)
   ) u_pick (
      .if_valid_i   (if_req_valid),
      .d_valid_i    (d_req_valid),
      .starve_cnt_i (starve_q),
      .if_gnt_o     (if_gnt_raw),
      .d_gnt_o      (d_gnt_raw)
   );
`endif

   // Nothing is granted while reset is high, so a write presented in a
   // reset cycle never reaches the SRAM.
   assign if_gnt       = if_gnt_raw & ~reset;
   assign d_gnt        = d_gnt_raw  & ~reset;
   assign if_req_ready = if_gnt;
   assign d_req_ready  = d_gnt;

   // ------------------------------------------------------------------
   // SRAM drive
   // ------------------------------------------------------------------
   always_comb begin
      mem_en    = if_gnt | d_gnt;
      mem_we    = 4'b0000;
      mem_wdata = d_wdata;
      mem_addr  = if_addr[MEM_AW+1:2];
      if (d_gnt) begin
         mem_addr = d_addr[MEM_AW+1:2];
         if (d_we) begin
            mem_we = d_be;
         end
      end
   end

   // ------------------------------------------------------------------
   // Arbitration history
   // ------------------------------------------------------------------
`ifdef PRIRV32_ARB_RR_EN
   always_comb begin
      last_owner_d = last_owner_q;
      if (d_gnt) begin
         last_owner_d = OWN_D;
      end else if (if_gnt) begin
         last_owner_d = OWN_IF;
      end
   end
`else
   // Counts consecutive cycles where IF waits; saturates so the forced
   // grant condition stays true until IF is actually served.
   always_comb begin
      starve_d = starve_q;
      if (!if_req_valid || if_gnt) begin
         starve_d = '0;
      end else if (starve_q < STARVE_W'(STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Response pipeline
   // ------------------------------------------------------------------
   always_comb begin
      slot_d          = '0;
      slot_d.valid    = if_gnt | d_gnt;
      slot_d.owner    = d_gnt ? OWN_D : OWN_IF;
      slot_d.is_store = d_gnt & d_we;
   end

   // A response still in flight when reset rises is dropped.
   assign if_rsp_act = slot_q.valid && (slot_q.owner == OWN_IF) && !reset;
   assign d_rsp_act  = slot_q.valid && (slot_q.owner == OWN_D)  && !reset;

   // SRAM data arrives the cycle after the grant and is forwarded straight
   // to the owner while also being captured, so rdata holds between
   // responses without costing an extra cycle of latency.
   always_comb begin
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if (if_rsp_act) begin
         if_rdata_d = mem_rdata;
      end
      if (d_rsp_act) begin
         d_rdata_d = slot_q.is_store ? 32'h0 : mem_rdata;
      end
   end

   assign if_rsp_valid = if_rsp_act;
   assign d_rsp_valid  = d_rsp_act;
   assign if_rdata     = reset ? 32'h0 : if_rdata_d;
   assign d_rdata      = reset ? 32'h0 : d_rdata_d;

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q       <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
`ifdef PRIRV32_ARB_RR_EN
         last_owner_q <= OWN_IF;
`else
         starve_q     <= '0;
`endif
      end else begin
         slot_q       <= slot_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
`ifdef PRIRV32_ARB_RR_EN
         last_owner_q <= last_owner_d;
`else
         starve_q     <= starve_d;
`endif
      end
   end

endmodule : prirv32_mem_arbiter

// File: tb/tb_prirv32_mem_arbiter.sv
module tb_prirv32_mem_arbiter;

   localparam int MEM_AW = 12;
   localparam int SMAX   = 4;
   localparam int DEPTH  = 1 << MEM_AW;

   logic              clk;
   logic              reset;
   logic              if_req_valid, if_req_ready;
   logic [31:0]       if_addr;
   logic              if_rsp_valid;
   logic [31:0]       if_rdata;
   logic              d_req_valid, d_req_ready;
   logic [31:0]       d_addr;
   logic              d_we;
   logic [3:0]        d_be;
   logic [31:0]       d_wdata;
   logic              d_rsp_valid;
   logic [31:0]       d_rdata;
   logic              mem_en;
   logic [3:0]        mem_we;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   int checks = 0;
   int errors = 0;

   // bench SRAM (the DUT's memory) and the reference image of its contents
   logic [31:0] sram    [DEPTH];
   logic [31:0] ref_mem [DEPTH];

   // expected response queue: [33] valid, [32] owner is D, [31:0] data
   logic [33:0] exp_q[$];

   prirv32_mem_arbiter #(
      .MEM_AW     (MEM_AW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_addr      (if_addr),
      .if_rsp_valid (if_rsp_valid),
      .if_rdata     (if_rdata),
      .d_req_valid  (d_req_valid),
      .d_req_ready  (d_req_ready),
      .d_addr       (d_addr),
      .d_we         (d_we),
      .d_be         (d_be),
      .d_wdata      (d_wdata),
      .d_rsp_valid  (d_rsp_valid),
      .d_rdata      (d_rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // single-port synchronous SRAM, read-before-write, 1-cycle latency
   always @(posedge clk) begin
      logic [31:0] w;
      if (mem_en) begin
         mem_rdata <= sram[mem_addr];
         w = sram[mem_addr];
         for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
         end
         sram[mem_addr] <= w;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      if_req_valid = 1'b0;
      if_addr      = 32'h0;
      d_req_valid  = 1'b0;
      d_addr       = 32'h0;
      d_we         = 1'b0;
      d_be         = 4'h0;
      d_wdata      = 32'h0;
   endtask

   task automatic apply_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      sram[idx]    = v;
      ref_mem[idx] = v;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset        = 1'b1;
      if_req_valid = 1'b1;
      d_req_valid  = 1'b1;
      d_we         = 1'b1;
      d_be         = 4'hF;
      @(negedge clk);
      checks++;
      if (if_req_ready !== 1'b0 || d_req_ready !== 1'b0 || mem_en !== 1'b0 || mem_we !== 4'h0) begin
         errors++;
         $display("FAIL reset_comb: got irdy=%b drdy=%b en=%b we=%h expected all 0",
                  if_req_ready, d_req_ready, mem_en, mem_we);
      end
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs: got irv=%b drv=%b ird=%h drd=%h expected all 0",
                  if_rsp_valid, d_rsp_valid, if_rdata, d_rdata);
      end
      drive_idle();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_if_alone();
      set_word(4, 32'hDEAD_BEEF);
      drive_idle();
      if_req_valid = 1'b1;
      if_addr      = 32'h0000_0010;
      @(negedge clk);
      checks++;
      if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0 || mem_en !== 1'b1 ||
          mem_addr !== 12'd4 || mem_we !== 4'h0) begin
         errors++;
         $display("FAIL if_alone_grant: got irdy=%b drdy=%b en=%b addr=%0d we=%h expected 1 0 1 4 0",
                  if_req_ready, d_req_ready, mem_en, mem_addr, mem_we);
      end
      tick();
      if_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (if_rsp_valid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || d_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL if_alone_rsp: got irv=%b ird=%h drv=%b expected 1 deadbeef 0",
                  if_rsp_valid, if_rdata, d_rsp_valid);
      end
      tick();
      @(negedge clk);
      checks++;
      if (if_rsp_valid !== 1'b0 || if_rdata !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL if_rdata_hold: got irv=%b ird=%h expected 0 deadbeef", if_rsp_valid, if_rdata);
      end
   endtask

   task automatic test_store_load();
      set_word(8, 32'hAABB_CCDD);
      drive_idle();
      d_req_valid = 1'b1;
      d_addr      = 32'h20;
      d_we        = 1'b1;
      d_be        = 4'b0011;
      d_wdata     = 32'h1234_5678;
      @(negedge clk);
      checks++;
      if (d_req_ready !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 12'd8 || mem_wdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL store_drive: got drdy=%b we=%b addr=%0d wd=%h expected 1 0011 8 12345678",
                  d_req_ready, mem_we, mem_addr, mem_wdata);
      end
      ref_mem[8] = 32'hAABB_5678;
      tick();
      d_we = 1'b0;
      d_be = 4'h0;
      @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rdata !== 32'h0 || d_req_ready !== 1'b1 || mem_we !== 4'h0) begin
         errors++;
         $display("FAIL store_ack: got drv=%b drd=%h drdy=%b we=%h expected 1 0 1 0",
                  d_rsp_valid, d_rdata, d_req_ready, mem_we);
      end
      tick();
      d_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rdata !== ref_mem[8] || if_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL load_after_store: got drv=%b drd=%h irv=%b expected 1 %h 0",
                  d_rsp_valid, d_rdata, if_rsp_valid, ref_mem[8]);
      end
      tick();
   endtask

   task automatic test_priority_pattern();
      logic prev_if;
      logic exp_if;
      drive_idle();
      apply_reset(2);
      set_word(16, 32'h1111_AAAA);
      set_word(32, 32'h2222_BBBB);
      if_req_valid = 1'b1;
      if_addr      = 32'h40;
      d_req_valid  = 1'b1;
      d_addr       = 32'h80;
      prev_if      = 1'b0;
      for (int k = 0; k < 15; k++) begin
`ifdef PRIRV32_ARB_RR_EN
         exp_if = (k % 2) == 1;
`else
         exp_if = (k % (SMAX + 1)) == SMAX;
`endif
         @(negedge clk);
         checks++;
         if (if_req_ready !== exp_if || d_req_ready !== !exp_if) begin
            errors++;
            $display("FAIL prio_grant[%0d]: got irdy=%b drdy=%b expected %b %b",
                     k, if_req_ready, d_req_ready, exp_if, !exp_if);
         end
         if (k > 0) begin
            checks++;
            if (if_rsp_valid !== prev_if || d_rsp_valid !== !prev_if ||
                (prev_if && if_rdata !== 32'h1111_AAAA) || (!prev_if && d_rdata !== 32'h2222_BBBB)) begin
               errors++;
               $display("FAIL prio_rsp[%0d]: got irv=%b drv=%b ird=%h drd=%h expected irv=%b drv=%b",
                        k, if_rsp_valid, d_rsp_valid, if_rdata, d_rdata, prev_if, !prev_if);
            end
         end
         prev_if = exp_if;
         tick();
      end
      drive_idle();
      tick();
   endtask

   task automatic test_wrap();
      drive_idle();
      set_word(2, 32'hC0FF_EE02);
      d_req_valid = 1'b1;
      d_addr      = 32'h0000_4008;
      @(negedge clk);
      checks++;
      if (mem_addr !== 12'd2 || d_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL wrap_addr: got addr=%0d drdy=%b expected 2 1", mem_addr, d_req_ready);
      end
      tick();
      d_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rdata !== 32'hC0FF_EE02) begin
         errors++;
         $display("FAIL wrap_data: got drv=%b drd=%h expected 1 c0ffee02", d_rsp_valid, d_rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      drive_idle();
      set_word(20, 32'h5555_0014);
      d_req_valid = 1'b1;
      d_addr      = 32'h50;
      tick();
      reset        = 1'b1;
      if_req_valid = 1'b1;
      d_we         = 1'b1;
      d_be         = 4'hF;
      d_wdata      = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0 || if_req_ready !== 1'b0 ||
          d_req_ready !== 1'b0 || mem_en !== 1'b0 || mem_we !== 4'h0) begin
         errors++;
         $display("FAIL reset_mid_drop: got drv=%b irv=%b irdy=%b drdy=%b en=%b we=%h expected all 0",
                  d_rsp_valid, if_rsp_valid, if_req_ready, d_req_ready, mem_en, mem_we);
      end
      tick();
      @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b0 || d_rdata !== 32'h0 || if_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_regs: got drv=%b drd=%h ird=%h expected 0 0 0", d_rsp_valid, d_rdata, if_rdata);
      end
      tick();
      reset        = 1'b0;
      if_req_valid = 1'b0;
      d_we         = 1'b0;
      d_be         = 4'h0;
      @(negedge clk);
      checks++;
      if (d_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 12'd20) begin
         errors++;
         $display("FAIL reset_mid_regrant: got drdy=%b en=%b addr=%0d expected 1 1 20", d_req_ready, mem_en, mem_addr);
      end
      tick();
      d_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rdata !== ref_mem[20]) begin
         errors++;
         $display("FAIL reset_mid_nowrite: got drv=%b drd=%h expected 1 %h", d_rsp_valid, d_rdata, ref_mem[20]);
      end
      tick();
   endtask

   task automatic test_random();
      int          m_denied;
      logic        m_last_d;
      logic        gi, gd, if_hold, d_hold;
      logic        e_if, e_d;
      logic [33:0] e;
      logic [11:0] wi, wd;
      logic [31:0] tmp;
      drive_idle();
      apply_reset(2);
      exp_q.delete();
      m_denied = 0;
      m_last_d = 1'b0;
      if_hold  = 1'b0;
      d_hold   = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (!if_hold) begin
            if_req_valid = ($urandom_range(0, 3) != 0);
            if_addr      = $urandom;
         end
         if (!d_hold) begin
            d_req_valid = ($urandom_range(0, 3) != 0);
            d_addr      = $urandom;
            d_we        = $urandom_range(0, 1);
            d_be        = 4'($urandom_range(0, 15));
            d_wdata     = $urandom;
         end
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            e_if = e[33] & !e[32];
            e_d  = e[33] & e[32];
            checks++;
            if (if_rsp_valid !== e_if || d_rsp_valid !== e_d ||
                (e_if && if_rdata !== e[31:0]) || (e_d && d_rdata !== e[31:0])) begin
               errors++;
               $display("FAIL rand_rsp[%0d]: got irv=%b drv=%b ird=%h drd=%h expected irv=%b drv=%b data=%h",
                        n, if_rsp_valid, d_rsp_valid, if_rdata, d_rdata, e_if, e_d, e[31:0]);
            end
         end
         // reference arbitration rule
`ifdef PRIRV32_ARB_RR_EN
         gi = if_req_valid && (!d_req_valid || m_last_d);
`else
         gi = if_req_valid && (!d_req_valid || m_denied >= SMAX);
`endif
         gd = d_req_valid && !gi;
         wi = if_addr[13:2];
         wd = d_addr[13:2];
         checks++;
         if (if_req_ready !== gi || d_req_ready !== gd || mem_en !== (gi | gd) ||
             ((gi | gd) && mem_addr !== (gd ? wd : wi)) ||
             mem_we !== ((gd && d_we) ? d_be : 4'h0) ||
             (gd && d_we && mem_wdata !== d_wdata)) begin
            errors++;
            $display("FAIL rand_req[%0d]: got irdy=%b drdy=%b en=%b addr=%0d we=%h expected irdy=%b drdy=%b addr=%0d",
                     n, if_req_ready, d_req_ready, mem_en, mem_addr, mem_we, gi, gd, gd ? wd : wi);
         end
         if (gi) begin
            exp_q.push_back({1'b1, 1'b0, ref_mem[wi]});
         end else if (gd && !d_we) begin
            exp_q.push_back({1'b1, 1'b1, ref_mem[wd]});
         end else if (gd) begin
            exp_q.push_back({1'b1, 1'b1, 32'h0});
            tmp = ref_mem[wd];
            for (int b = 0; b < 4; b++) begin
               if (d_be[b]) tmp[8*b +: 8] = d_wdata[8*b +: 8];
            end
            ref_mem[wd] = tmp;
         end else begin
            exp_q.push_back(34'h0);
         end
         if (if_req_valid && !gi) m_denied = (m_denied < SMAX) ? m_denied + 1 : SMAX;
         else m_denied = 0;
         if (gi) m_last_d = 1'b0;
         if (gd) m_last_d = 1'b1;
         if_hold = if_req_valid && !gi;
         d_hold  = d_req_valid && !gd;
         tick();
      end
      drive_idle();
      @(negedge clk);
      if (exp_q.size() > 0) begin
         e    = exp_q.pop_front();
         e_if = e[33] & !e[32];
         e_d  = e[33] & e[32];
         checks++;
         if (if_rsp_valid !== e_if || d_rsp_valid !== e_d ||
             (e_if && if_rdata !== e[31:0]) || (e_d && d_rdata !== e[31:0])) begin
            errors++;
            $display("FAIL rand_drain: got irv=%b drv=%b ird=%h drd=%h expected irv=%b drv=%b data=%h",
                     if_rsp_valid, d_rsp_valid, if_rdata, d_rdata, e_if, e_d, e[31:0]);
         end
      end
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      mem_rdata = 32'h0;
      for (int i = 0; i < DEPTH; i++) begin
         sram[i]    = $urandom;
         ref_mem[i] = sram[i];
      end
      drive_idle();
      reset = 1'b1;
      tick();
      test_reset();
      test_if_alone();
      test_store_load();
      test_priority_pattern();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_prirv32_mem_arbiter
